// File: rtl/ps2_key_input_pkg.sv
// Shared constants, frame FSM states and parity helper for the PS/2 key receiver.
package ps2_key_input_pkg;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
    localparam logic [7:0] PS2_UP_CODE    = 8'h29;  // space bar
    localparam logic [7:0] PS2_MODE_CODE  = 8'h3A;  // "M"

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    // PS/2 uses odd parity over the 8 data bits plus the parity bit.
    function automatic logic ps2_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_key_input_if.sv
// PS/2 pins inward, decoded key events outward.
interface ps2_key_input_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] code;
    logic       code_valid;
    logic       is_break;
    logic       is_extended;
    logic       up_pulse;
    logic       up_held;
    logic       mode_toggle;
    logic       frame_err;

    // Keyboard side: drives the pins, observes the decoded events.
    modport master (
        output ps2_clk, ps2_data,
        input  code, code_valid, is_break, is_extended,
        input  up_pulse, up_held, mode_toggle, frame_err
    );

    // Receiver side.
    modport slave (
        input  ps2_clk, ps2_data,
        output code, code_valid, is_break, is_extended,
        output up_pulse, up_held, mode_toggle, frame_err
    );
endinterface

// File: rtl/ps2_line_filter.sv
// Synchronizes both PS/2 pins, deglitches ps2_clk and flags its falling edges.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic data_o,
    output logic fe_o
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]    clk_sync_q, data_sync_q;
    logic          filt_q, filt_d, prev_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Filtered level flips only after FILTER_LEN consecutive samples disagree with it.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (clk_sync_q[1] != filt_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizers, filter state and previous filtered level; idle bus is high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= 1'b1;
            prev_q      <= 1'b1;
            cnt_q       <= '0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
            filt_q      <= filt_d;
            prev_q      <= filt_q;
            cnt_q       <= cnt_d;
        end
    end

    assign fe_o   = prev_q & ~filt_q;
    assign data_o = data_sync_q[1];

endmodule

// File: rtl/ps2_key_input.sv
// PS/2 frame receiver, prefix stripper and flap/mode key mapper.
module ps2_key_input
    import ps2_key_input_pkg::*;
#(
    parameter int         FILTER_LEN     = 8,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter logic [7:0] UP_CODE        = PS2_UP_CODE,
    parameter logic [7:0] MODE_CODE      = PS2_MODE_CODE
) (
    input  logic           clk,
    input  logic           rst,
    ps2_key_input_if.slave bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          fe, din;
    ps2_state_e    state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          ext_q, ext_d, brk_q, brk_d;
    logic          up_held_q, up_held_d, mode_held_q, mode_held_d;
    logic [7:0]    code_q, code_d;
    logic          cv_q, cv_d, isb_q, isb_d, ise_q, ise_d;
    logic          upp_q, upp_d, mtg_q, mtg_d, err_q, err_d;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk_i (bus.ps2_clk),
        .ps2_data_i(bus.ps2_data),
        .data_o    (din),
        .fe_o      (fe)
    );

    // Frame FSM, timeout watchdog, prefix tracking and key mapping.
    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        tmo_d       = '0;
        ext_d       = ext_q;
        brk_d       = brk_q;
        up_held_d   = up_held_q;
        mode_held_d = mode_held_q;
        code_d      = code_q;
        isb_d       = isb_q;
        ise_d       = ise_q;
        cv_d        = 1'b0;
        upp_d       = 1'b0;
        mtg_d       = 1'b0;
        err_d       = 1'b0;
        if (fe) begin
            // An edge always wins over a coincident timeout.
            unique case (state_q)
                IDLE: begin
                    if (!din) begin
                        state_d  = DATA;
                        bitcnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d  = {din, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = din;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (ps2_parity_ok(shift_q, par_q) && din) begin
                        if (shift_q == PS2_PREFIX_EXT) begin
                            ext_d = 1'b1;
                        end else if (shift_q == PS2_PREFIX_BRK) begin
                            brk_d = 1'b1;
                        end else begin
                            cv_d   = 1'b1;
                            code_d = shift_q;
                            isb_d  = brk_q;
                            ise_d  = ext_q;
                            ext_d  = 1'b0;
                            brk_d  = 1'b0;
                            // Extended codes never map, even with a matching low byte.
                            if (!ext_q && shift_q == UP_CODE) begin
                                if (brk_q) begin
                                    up_held_d = 1'b0;
                                end else if (!up_held_q) begin
                                    upp_d     = 1'b1;
                                    up_held_d = 1'b1;
                                end
                            end
                            if (!ext_q && shift_q == MODE_CODE) begin
                                if (brk_q) begin
                                    mode_held_d = 1'b0;
                                end else if (!mode_held_q) begin
                                    mtg_d       = 1'b1;
                                    mode_held_d = 1'b1;
                                end
                            end
                        end
                    end else begin
                        err_d = 1'b1;
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            if (tmo_q == TW'(TIMEOUT_CYCLES)) begin
                err_d   = 1'b1;
                state_d = IDLE;
                ext_d   = 1'b0;
                brk_d   = 1'b0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    // State and output registers; reset drops any partial frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            up_held_q   <= 1'b0;
            mode_held_q <= 1'b0;
            code_q      <= '0;
            cv_q        <= 1'b0;
            isb_q       <= 1'b0;
            ise_q       <= 1'b0;
            upp_q       <= 1'b0;
            mtg_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            tmo_q       <= tmo_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            up_held_q   <= up_held_d;
            mode_held_q <= mode_held_d;
            code_q      <= code_d;
            cv_q        <= cv_d;
            isb_q       <= isb_d;
            ise_q       <= ise_d;
            upp_q       <= upp_d;
            mtg_q       <= mtg_d;
            err_q       <= err_d;
        end
    end

    assign bus.code        = code_q;
    assign bus.code_valid  = cv_q;
    assign bus.is_break    = isb_q;
    assign bus.is_extended = ise_q;
    assign bus.up_pulse    = upp_q;
    assign bus.up_held     = up_held_q;
    assign bus.mode_toggle = mtg_q;
    assign bus.frame_err   = err_q;

endmodule

// File: tb/tb_ps2_key_input.sv
// Scoreboard bench: expected key events are queued as frames are driven and
// matched against code_valid / frame_err strobes as they appear.
module tb_ps2_key_input;

    localparam int HALF = 40;  // PS/2 half bit period in clk cycles (scaled down)

    typedef struct packed {
        logic       err;
        logic [7:0] code;
        logic       brk;
        logic       ext;
        logic       up;
        logic       mode;
    } ev_t;

    logic clk, rst;
    int   errors = 0;
    int   checks = 0;
    ev_t  sb[$];

    ps2_key_input_if bus ();

    ps2_key_input #(
        .FILTER_LEN    (4),
        .TIMEOUT_CYCLES(2000),
        .UP_CODE       (8'h29),
        .MODE_CODE     (8'h3A)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic exp_code(input logic [7:0] c, input logic b, input logic e,
                            input logic u, input logic m);
        ev_t ev;
        ev = '{err: 1'b0, code: c, brk: b, ext: e, up: u, mode: m};
        sb.push_back(ev);
    endtask

    task automatic exp_err();
        ev_t ev;
        ev = '{err: 1'b1, code: 8'h00, brk: 1'b0, ext: 1'b0, up: 1'b0, mode: 1'b0};
        sb.push_back(ev);
    endtask

    // Drive the first nbits of an 11-bit frame, start bit first, data LSB first.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            bus.ps2_data = f[i];
            repeat (HALF) @(negedge clk);
            bus.ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            bus.ps2_clk = 1'b1;
        end
        bus.ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clk);
        chk(tag, sb.size(), 0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk({tag, "_code"}, 32'(bus.code), 0);
        chk({tag, "_strobes"}, {bus.code_valid, bus.up_pulse, bus.mode_toggle, bus.frame_err}, 0);
        chk({tag, "_flags"}, {bus.is_break, bus.is_extended, bus.up_held}, 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    // Event monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin : mon
        ev_t e;
        if (rst === 1'b1 && (bus.code_valid || bus.frame_err)) begin
            if (sb.size() == 0) begin
                chk("unexpected_event", {bus.code_valid, bus.frame_err}, 0);
            end else begin
                e = sb.pop_front();
                chk("frame_err", 32'(bus.frame_err), 32'(e.err));
                if (e.err) begin
                    chk("err_no_cv", {bus.code_valid, bus.up_pulse, bus.mode_toggle}, 0);
                end else begin
                    chk("code", 32'(bus.code), 32'(e.code));
                    chk("is_break", 32'(bus.is_break), 32'(e.brk));
                    chk("is_ext", 32'(bus.is_extended), 32'(e.ext));
                    chk("up_pulse", 32'(bus.up_pulse), 32'(e.up));
                    chk("mode_toggle", 32'(bus.mode_toggle), 32'(e.mode));
                end
            end
        end else if (rst === 1'b1 && (bus.up_pulse || bus.mode_toggle)) begin
            chk("stray_strobe", {bus.up_pulse, bus.mode_toggle}, 0);
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: bench exceeded its cycle budget, pending=%0d", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        rst          = 1'b0;
        do_reset("reset");

        // Single good space-bar make.
        exp_code(8'h29, 0, 0, 1, 0);
        send_frame(8'h29, 0, 11);
        drain("good_29");
        chk("held_after_make", 32'(bus.up_held), 1);

        // Release, then fresh make followed by typematic repeats, then release.
        exp_code(8'h29, 1, 0, 0, 0);
        send_frame(8'hF0, 0, 11);
        send_frame(8'h29, 0, 11);
        chk("held_after_break", 32'(bus.up_held), 0);
        exp_code(8'h29, 0, 0, 1, 0);
        exp_code(8'h29, 0, 0, 0, 0);
        exp_code(8'h29, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) send_frame(8'h29, 0, 11);
        exp_code(8'h29, 1, 0, 0, 0);
        send_frame(8'hF0, 0, 11);
        send_frame(8'h29, 0, 11);
        drain("typematic");
        chk("held_after_release", 32'(bus.up_held), 0);

        // Bad parity while the key is held: error only, held flag untouched.
        exp_code(8'h29, 0, 0, 1, 0);
        send_frame(8'h29, 0, 11);
        exp_err();
        send_frame(8'h29, 1, 11);
        drain("bad_parity");
        chk("held_after_bad_par", 32'(bus.up_held), 1);
        exp_code(8'h29, 1, 0, 0, 0);
        send_frame(8'hF0, 0, 11);
        send_frame(8'h29, 0, 11);

        // Abandoned frame times out, then a good mode key.
        exp_err();
        send_frame(8'h55, 0, 5);
        repeat (2500) @(negedge clk);
        exp_code(8'h3A, 0, 0, 0, 1);
        send_frame(8'h3A, 0, 11);
        drain("timeout_then_mode");

        // Extended code with the flap low byte never maps.
        exp_code(8'h29, 0, 1, 0, 0);
        send_frame(8'hE0, 0, 11);
        send_frame(8'h29, 0, 11);
        drain("extended");
        chk("held_after_ext", 32'(bus.up_held), 0);

        // Hold the key, then reset mid-frame: held flag must clear.
        exp_code(8'h29, 0, 0, 1, 0);
        send_frame(8'h29, 0, 11);
        drain("pre_reset");
        send_frame(8'h29, 0, 4);
        do_reset("mid_reset");

        // Short clock glitch with data low must not start a frame.
        @(negedge clk);
        bus.ps2_data = 1'b0;
        bus.ps2_clk  = 1'b0;
        repeat (2) @(negedge clk);
        bus.ps2_clk  = 1'b1;
        repeat (20) @(negedge clk);
        bus.ps2_data = 1'b1;
        repeat (20) @(negedge clk);

        exp_code(8'h29, 0, 0, 1, 0);
        send_frame(8'h29, 0, 11);
        drain("post_reset");
        chk("held_post_reset", 32'(bus.up_held), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
